// File: rtl/snake_control_fsm_pkg.sv
// rtl/snake_control_fsm_pkg.sv - state, direction and colour codes shared by the snake control FSM
package snake_control_fsm_pkg;

  typedef enum logic [4:0] {
    S_INIT,
    S_FILL,
    S_WAIT,
    S_UPD,
    S_LDP,
    S_RD,
    S_CUR,
    S_WR,
    S_SH,
    S_CHK,
    S_GROW,
    S_ERASE,
    S_DRD,
    S_DPIX,
    S_FOOD,
    S_DCHK,
    S_DEAD
  } state_e;

  localparam logic [2:0] DIR_UP    = 3'b100;
  localparam logic [2:0] DIR_DOWN  = 3'b110;
  localparam logic [2:0] DIR_RIGHT = 3'b001;
  localparam logic [2:0] DIR_LEFT  = 3'b000;

  localparam logic [2:0] COL_BODY  = 3'b111;
  localparam logic [2:0] COL_FOOD  = 3'b100;
  localparam logic [2:0] COL_ERASE = 3'b000;

  localparam int         CELL_PIX  = 16;
  localparam logic [3:0] CNT_LAST  = 4'(CELL_PIX - 1);

  // Vertical codes differ only in bit 1, horizontal codes only in bit 0
  function automatic logic [2:0] dir_reverse(input logic [2:0] d);
    return d[2] ? (d ^ 3'b010) : (d ^ 3'b001);
  endfunction

endpackage

// File: rtl/snake_dir_latch.sv
// rtl/snake_dir_latch.sv - key sampling, reversal filter and per-move direction latch
module snake_dir_latch
  import snake_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       apply,
  output logic [2:0] dir
);

  logic [2:0] dir_q, dir_d;
  logic [2:0] pend_q, pend_d;
  logic [2:0] req;
  logic [2:0] ref_dir;
  logic       req_valid;

  // Pick the highest-priority key; reject it if it reverses the direction the next move will use
  always_comb begin
    req_valid = 1'b1;
    req       = DIR_UP;
    if (key_up)         req = DIR_UP;
    else if (key_down)  req = DIR_DOWN;
    else if (key_left)  req = DIR_LEFT;
    else if (key_right) req = DIR_RIGHT;
    else                req_valid = 1'b0;
    // On the apply cycle the pending value is about to become current, so filter against it
    ref_dir = apply ? pend_q : dir_q;
    pend_d  = pend_q;
    if (req_valid && (req != dir_reverse(ref_dir))) pend_d = req;
    dir_d   = apply ? pend_q : dir_q;
  end

  // Pending and applied direction registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dir_q  <= DIR_UP;
      pend_q <= DIR_UP;
    end else begin
      dir_q  <= dir_d;
      pend_q <= pend_d;
    end
  end

  assign dir = dir_q;

endmodule

// File: rtl/snake_control_fsm.sv
// rtl/snake_control_fsm.sv - move sequencer for the snake datapath: init, shift, grow/erase, redraw, death
module snake_control_fsm
  import snake_control_fsm_pkg::*;
#(
  parameter int INIT_LEN = 4,
  parameter int MAX_LEN  = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_tick,
  input  logic       key_up,
  input  logic       key_down,
  input  logic       key_left,
  input  logic       key_right,
  input  logic       isDead,
  input  logic       inc_length,
  output logic       ld_head,
  output logic       ld_q_def,
  output logic       inc_address,
  output logic       rst_address,
  output logic       draw_q,
  output logic       update_head,
  output logic       ld_head_into_prev,
  output logic       ld_q_into_curr,
  output logic       ld_prev_into_q,
  output logic       ld_curr_into_prev,
  output logic       draw_curr,
  output logic       food_en,
  output logic       check_inc,
  output logic       lock,
  output logic [3:0] cnt_status,
  output logic [2:0] dir,
  output logic [2:0] colour,
  output logic       dead
);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [10:0] idx_q, idx_d;
  logic [10:0] len_q, len_d;
  logic        started_q;
  logic        dead_q;
  logic        idx_last, cnt_last, dir_apply;

  assign idx_last  = (idx_q == len_q - 11'd1);
  assign cnt_last  = (cnt_q == CNT_LAST);
  assign dir_apply = (state_q == S_WAIT) && move_tick;

  snake_dir_latch u_dir (
    .clk       (clk),
    .rst       (rst),
    .key_up    (key_up),
    .key_down  (key_down),
    .key_left  (key_left),
    .key_right (key_right),
    .apply     (dir_apply),
    .dir       (dir)
  );

  // State, pixel counter, segment index and length registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_INIT;
      cnt_q     <= 4'd0;
      idx_q     <= 11'd0;
      len_q     <= 11'(INIT_LEN);
      started_q <= 1'b0;
      dead_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      len_q     <= len_d;
      started_q <= 1'b1;
      dead_q    <= (state_d == S_DEAD);
    end
  end

  // Next-state logic and Moore strobe decode; INIT stays quiet for the first cycle out of reset
  always_comb begin
    state_d           = state_q;
    cnt_d             = 4'd0;
    idx_d             = idx_q;
    len_d             = len_q;
    ld_head           = 1'b0;
    ld_q_def          = 1'b0;
    inc_address       = 1'b0;
    rst_address       = 1'b0;
    draw_q            = 1'b0;
    update_head       = 1'b0;
    ld_head_into_prev = 1'b0;
    ld_q_into_curr    = 1'b0;
    ld_prev_into_q    = 1'b0;
    ld_curr_into_prev = 1'b0;
    draw_curr         = 1'b0;
    food_en           = 1'b0;
    check_inc         = 1'b0;
    lock              = 1'b0;
    colour            = COL_ERASE;
    case (state_q)
      S_INIT: begin
        if (started_q) begin
          ld_head     = 1'b1;
          rst_address = 1'b1;
          idx_d       = 11'd0;
          state_d     = S_FILL;
        end
      end
      S_FILL: begin
        ld_q_def    = 1'b1;
        inc_address = 1'b1;
        if (idx_q == 11'(INIT_LEN - 1)) begin
          idx_d   = 11'd0;
          state_d = S_WAIT;
        end else begin
          idx_d = idx_q + 11'd1;
        end
      end
      S_WAIT: begin
        lock = 1'b1;
        if (move_tick) state_d = S_UPD;
      end
      S_UPD: begin
        update_head = 1'b1;
        state_d     = S_LDP;
      end
      S_LDP: begin
        ld_head_into_prev = 1'b1;
        rst_address       = 1'b1;
        idx_d             = 11'd0;
        state_d           = S_RD;
      end
      S_RD:  state_d = S_CUR;
      S_CUR: begin
        ld_q_into_curr = 1'b1;
        state_d        = S_WR;
      end
      S_WR: begin
        ld_prev_into_q = 1'b1;
        state_d        = S_SH;
      end
      S_SH: begin
        ld_curr_into_prev = 1'b1;
        inc_address       = 1'b1;
        if (idx_last) begin
          idx_d   = 11'd0;
          state_d = S_CHK;
        end else begin
          idx_d   = idx_q + 11'd1;
          state_d = S_RD;
        end
      end
      S_CHK: begin
        check_inc = 1'b1;
        state_d   = (inc_length && (len_q < 11'(MAX_LEN))) ? S_GROW : S_ERASE;
      end
      // Address already points one past the tail here, so the old tail is kept in place
      S_GROW: begin
        ld_prev_into_q = 1'b1;
        rst_address    = 1'b1;
        len_d          = len_q + 11'd1;
        idx_d          = 11'd0;
        state_d        = S_DRD;
      end
      S_ERASE: begin
        draw_curr = 1'b1;
        cnt_d     = cnt_q + 4'd1;
        if (cnt_last) begin
          rst_address = 1'b1;
          idx_d       = 11'd0;
          state_d     = S_DRD;
        end
      end
      S_DRD: state_d = S_DPIX;
      S_DPIX: begin
        draw_q = 1'b1;
        colour = COL_BODY;
        cnt_d  = cnt_q + 4'd1;
        if (cnt_last) begin
          inc_address = 1'b1;
          if (idx_last) begin
            idx_d   = 11'd0;
            state_d = S_FOOD;
          end else begin
            idx_d   = idx_q + 11'd1;
            state_d = S_DRD;
          end
        end
      end
      S_FOOD: begin
        food_en = 1'b1;
        colour  = COL_FOOD;
        cnt_d   = cnt_q + 4'd1;
        if (cnt_last) state_d = S_DCHK;
      end
      S_DCHK:  state_d = isDead ? S_DEAD : S_WAIT;
      S_DEAD:  state_d = S_DEAD;
      default: state_d = S_INIT;
    endcase
  end

  assign cnt_status = cnt_q;
  assign dead       = dead_q;

endmodule

// File: tb/tb_snake_control_fsm.sv
// tb/tb_snake_control_fsm.sv - randomized and directed bench for snake_control_fsm with a move-schedule model
module tb_snake_control_fsm;

  localparam int INIT_LEN = 4;
  localparam int MAX_LEN  = 8;

  localparam logic [13:0] B_LD_HEAD = 14'(1) << 13;
  localparam logic [13:0] B_QDEF    = 14'(1) << 12;
  localparam logic [13:0] B_INCA    = 14'(1) << 11;
  localparam logic [13:0] B_RSTA    = 14'(1) << 10;
  localparam logic [13:0] B_DRAWQ   = 14'(1) << 9;
  localparam logic [13:0] B_UPD     = 14'(1) << 8;
  localparam logic [13:0] B_HIP     = 14'(1) << 7;
  localparam logic [13:0] B_QIC     = 14'(1) << 6;
  localparam logic [13:0] B_PIQ     = 14'(1) << 5;
  localparam logic [13:0] B_CIP     = 14'(1) << 4;
  localparam logic [13:0] B_DCUR    = 14'(1) << 3;
  localparam logic [13:0] B_FOOD    = 14'(1) << 2;
  localparam logic [13:0] B_CHK     = 14'(1) << 1;
  localparam logic [13:0] B_LOCK    = 14'(1);

  logic clk = 1'b0, rst = 1'b0, move_tick = 1'b0;
  logic key_up = 1'b0, key_down = 1'b0, key_left = 1'b0, key_right = 1'b0;
  logic isDead = 1'b0, inc_length = 1'b0;
  logic ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head;
  logic ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev;
  logic draw_curr, food_en, check_inc, lock, dead;
  logic [3:0] cnt_status;
  logic [2:0] dir, colour;
  logic [13:0] stb;

  always #5 clk = ~clk;

  snake_control_fsm #(.INIT_LEN(INIT_LEN), .MAX_LEN(MAX_LEN)) dut (
    .clk(clk), .rst(rst), .move_tick(move_tick),
    .key_up(key_up), .key_down(key_down), .key_left(key_left), .key_right(key_right),
    .isDead(isDead), .inc_length(inc_length),
    .ld_head(ld_head), .ld_q_def(ld_q_def), .inc_address(inc_address), .rst_address(rst_address),
    .draw_q(draw_q), .update_head(update_head), .ld_head_into_prev(ld_head_into_prev),
    .ld_q_into_curr(ld_q_into_curr), .ld_prev_into_q(ld_prev_into_q),
    .ld_curr_into_prev(ld_curr_into_prev), .draw_curr(draw_curr), .food_en(food_en),
    .check_inc(check_inc), .lock(lock), .cnt_status(cnt_status), .dir(dir),
    .colour(colour), .dead(dead)
  );

  assign stb = {ld_head, ld_q_def, inc_address, rst_address, draw_q, update_head,
                ld_head_into_prev, ld_q_into_curr, ld_prev_into_q, ld_curr_into_prev,
                draw_curr, food_en, check_inc, lock};

  int n_cmp = 0, n_fail = 0;
  int c_qdef = 0, c_upd = 0, c_piq = 0, c_dcur = 0, c_drawq = 0, c_food = 0, c_any = 0;

  // Model: expected output word per cycle = {strobes, cnt, colour, dead}
  logic [21:0] m_cur = '0;
  logic [21:0] m_q[$];
  bit          m_alive = 1'b1;
  int          m_len = INIT_LEN;
  logic [2:0]  m_dir = 3'b100, m_pend = 3'b100;

  function automatic logic [21:0] vec(input logic [13:0] s, input int c, input logic [2:0] col, input logic d);
    return {s, 4'(c), col, d};
  endfunction

  function automatic logic [2:0] opposite(input logic [2:0] d);
    case (d)
      3'b100:  return 3'b110;
      3'b110:  return 3'b100;
      3'b001:  return 3'b000;
      default: return 3'b001;
    endcase
  endfunction

  // Lay out a whole move as a list of per-cycle output words
  task automatic push_move(input bit inc, input bit die);
    bit grow;
    grow = inc && (m_len < MAX_LEN);
    m_q.push_back(vec(B_UPD, 0, 3'b000, 1'b0));
    m_q.push_back(vec(B_HIP | B_RSTA, 0, 3'b000, 1'b0));
    for (int i = 0; i < m_len; i++) begin
      m_q.push_back(vec(14'b0, 0, 3'b000, 1'b0));
      m_q.push_back(vec(B_QIC, 0, 3'b000, 1'b0));
      m_q.push_back(vec(B_PIQ, 0, 3'b000, 1'b0));
      m_q.push_back(vec(B_CIP | B_INCA, 0, 3'b000, 1'b0));
    end
    m_q.push_back(vec(B_CHK, 0, 3'b000, 1'b0));
    if (grow) begin
      m_q.push_back(vec(B_PIQ | B_RSTA, 0, 3'b000, 1'b0));
      m_len = m_len + 1;
    end else begin
      for (int k = 0; k < 16; k++)
        m_q.push_back(vec(B_DCUR | ((k == 15) ? B_RSTA : 14'b0), k, 3'b000, 1'b0));
    end
    for (int i = 0; i < m_len; i++) begin
      m_q.push_back(vec(14'b0, 0, 3'b000, 1'b0));
      for (int k = 0; k < 16; k++)
        m_q.push_back(vec(B_DRAWQ | ((k == 15) ? B_INCA : 14'b0), k, 3'b111, 1'b0));
    end
    for (int k = 0; k < 16; k++) m_q.push_back(vec(B_FOOD, k, 3'b100, 1'b0));
    m_q.push_back(vec(14'b0, 0, 3'b000, 1'b0));
    if (die) m_alive = 1'b0;
  endtask

  // Reference model advances one cycle per clock edge
  always @(posedge clk) begin
    logic       apply;
    logic [2:0] req, ref_d;
    bit         req_v;
    if (!rst) begin
      m_q.delete();
      m_cur   = '0;
      m_alive = 1'b1;
      m_len   = INIT_LEN;
      m_dir   = 3'b100;
      m_pend  = 3'b100;
      m_q.push_back(vec(B_LD_HEAD | B_RSTA, 0, 3'b000, 1'b0));
      for (int i = 0; i < INIT_LEN; i++) m_q.push_back(vec(B_QDEF | B_INCA, 0, 3'b000, 1'b0));
    end else begin
      apply = m_cur[8] && move_tick;
      ref_d = apply ? m_pend : m_dir;
      req_v = 1'b1;
      if (key_up)         req = 3'b100;
      else if (key_down)  req = 3'b110;
      else if (key_left)  req = 3'b000;
      else if (key_right) req = 3'b001;
      else begin req_v = 1'b0; req = 3'b000; end
      if (apply) begin
        push_move(inc_length, isDead);
        m_dir = m_pend;
      end
      if (req_v && (req != opposite(ref_d))) m_pend = req;
      if (m_q.size() > 0) m_cur = m_q.pop_front();
      else                m_cur = m_alive ? vec(B_LOCK, 0, 3'b000, 1'b0) : vec(14'b0, 0, 3'b000, 1'b1);
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // One clock: sample away from the edge, compare against the model, tally strobes
  task automatic step();
    logic [21:0] act;
    @(posedge clk);
    #2;
    act = {stb, cnt_status, colour, dead};
    n_cmp++;
    if (act !== m_cur) begin
      n_fail++;
      $display("FAIL outputs actual=%h required=%h t=%0t", act, m_cur, $time);
    end
    n_cmp++;
    if (dir !== m_dir) begin
      n_fail++;
      $display("FAIL dir actual=%b required=%b t=%0t", dir, m_dir, $time);
    end
    c_qdef  += int'(ld_q_def);
    c_upd   += int'(update_head);
    c_piq   += int'(ld_prev_into_q);
    c_dcur  += int'(draw_curr);
    c_drawq += int'(draw_q);
    c_food  += int'(food_en);
    c_any   += int'(stb != 14'b0);
  endtask

  task automatic wait_lock(input string name);
    int n;
    n = 0;
    while (!lock && n < 1000) begin step(); n++; end
    check(name, int'(lock), 1);
  endtask

  task automatic do_move(input bit inc, input bit die);
    int n;
    inc_length = inc;
    isDead     = die;
    move_tick  = 1'b1;
    step();
    move_tick  = 1'b0;
    n = 0;
    while (!(lock || dead) && n < 3000) begin step(); n++; end
    check("move_done", int'(lock || dead), 1);
  endtask

  initial begin
    int b_qdef, b_upd, b_piq, b_dcur, b_drawq, b_food, b_any, n;

    repeat (3) step();
    check("reset_dir", int'(dir), 4);
    check("reset_dead", int'(dead), 0);
    check("reset_strobes", int'(stb), 0);
    check("reset_cnt", int'(cnt_status), 0);

    b_qdef = c_qdef;
    rst = 1'b1;
    wait_lock("init_to_wait");
    check("fill_ld_q_def", c_qdef - b_qdef, 4);
    check("wait_dir", int'(dir), 4);

    key_down = 1'b1;
    repeat (3) step();
    b_upd = c_upd; b_piq = c_piq; b_dcur = c_dcur; b_drawq = c_drawq; b_food = c_food;
    do_move(1'b0, 1'b0);
    key_down = 1'b0;
    check("down_ignored_dir", int'(dir), 4);
    check("m1_update_head", c_upd - b_upd, 1);
    check("m1_ld_prev_into_q", c_piq - b_piq, 4);
    check("m1_draw_curr", c_dcur - b_dcur, 16);
    check("m1_draw_q", c_drawq - b_drawq, 64);
    check("m1_food_en", c_food - b_food, 16);

    key_right = 1'b1;
    step();
    key_right = 1'b0;
    repeat (3) step();
    check("dir_before_upd", int'(dir), 4);
    b_piq = c_piq; b_dcur = c_dcur; b_drawq = c_drawq;
    do_move(1'b1, 1'b0);
    check("dir_after_upd", int'(dir), 1);
    check("grow_draw_curr", c_dcur - b_dcur, 0);
    check("grow_ld_prev_into_q", c_piq - b_piq, 5);
    check("grow_draw_q", c_drawq - b_drawq, 80);

    b_dcur = c_dcur; b_drawq = c_drawq;
    do_move(1'b0, 1'b0);
    check("len5_draw_q", c_drawq - b_drawq, 80);
    check("len5_draw_curr", c_dcur - b_dcur, 16);

    for (int i = 0; i < 3000; i++) begin
      key_up    = ($urandom_range(0, 3) == 0);
      key_down  = ($urandom_range(0, 3) == 0);
      key_left  = ($urandom_range(0, 3) == 0);
      key_right = ($urandom_range(0, 3) == 0);
      move_tick = ($urandom_range(0, 4) == 0);
      if (m_cur[8]) inc_length = ($urandom_range(0, 1) == 1);
      step();
    end
    key_up = 1'b0; key_down = 1'b0; key_left = 1'b0; key_right = 1'b0; move_tick = 1'b0;
    wait_lock("random_settle");

    n = 0;
    while (m_len < MAX_LEN && n < 20) begin do_move(1'b1, 1'b0); n++; end
    b_piq = c_piq; b_dcur = c_dcur; b_drawq = c_drawq;
    do_move(1'b1, 1'b0);
    check("max_draw_curr", c_dcur - b_dcur, 16);
    check("max_ld_prev_into_q", c_piq - b_piq, 8);
    check("max_draw_q", c_drawq - b_drawq, 128);

    inc_length = 1'b0;
    move_tick  = 1'b1;
    step();
    move_tick  = 1'b0;
    n = 0;
    while (!ld_q_into_curr && n < 50) begin step(); n++; end
    check("reached_shift", int'(ld_q_into_curr), 1);
    rst = 1'b0;
    step();
    check("midreset_strobes", int'(stb), 0);
    check("midreset_dir", int'(dir), 4);
    rst = 1'b1;
    b_qdef = c_qdef;
    wait_lock("reinit_to_wait");
    check("refill_ld_q_def", c_qdef - b_qdef, 4);

    b_food = c_food;
    do_move(1'b0, 1'b1);
    check("dead_flag", int'(dead), 1);
    check("dead_after_food", c_food - b_food, 16);
    b_any = c_any;
    for (int i = 0; i < 40; i++) begin
      move_tick = ((i % 8) == 0);
      step();
    end
    move_tick = 1'b0;
    check("dead_no_strobes", c_any - b_any, 0);
    check("dead_hold", int'(dead), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
